hwpe_stream_tcdm_addr_reader: RTL and testbench

- Consumer end of the v2 address stream. It takes the 36-bit address/flag stream produced by the streamer address generator and issues single-word read requests on one TCDM port.
- It collects the fixed-latency responses and emits a 32-bit data stream whose strobe and misalignment flags are carried from the originating address beat.
- It sits between the address generator and the realigner/source FIFO in a streamer source path.

---
 rtl/hwpe_stream_tcdm_addr_reader_if.sv | 27 ++
 rtl/hwpe_stream_tcdm_addr_reader.sv | 219 +++++++++++++++++++++
 tb/tb_hwpe_stream_tcdm_addr_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_tcdm_addr_reader_if.sv
// Stream handshake bundle (valid/ready/data/strb) and the status flag bundle
// exported by the TCDM address reader.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);
endinterface

interface hwpe_stream_tcdm_addr_reader_flags_if ();
    logic busy;
    logic error;
    logic misalign;
    logic first;
    logic last;

    modport master (output busy, output error, output misalign, output first, output last);
    modport slave  (input busy, input error, input misalign, input first, input last);
endinterface

// File: rtl/hwpe_stream_tcdm_addr_reader.sv
// Turns a stream of word addresses into single-word TCDM reads and returns the
// fixed-latency read data as a stream, carrying strobe/misalign tags per beat.
module hwpe_stream_tcdm_addr_reader_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST_C) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_ONE_C;
        end
        return nxt;
    endfunction

    assign empty_o = (cnt_q == {CNT_W{1'b0}});
    assign pop_s   = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_s  = push_i & ((cnt_q != CNT_FULL_C) | pop_s);
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE_C;
            2'b01:   cnt_d = cnt_q - CNT_ONE_C;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy state with reset and soft clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

module hwpe_stream_tcdm_addr_reader #(
    parameter int unsigned OUT_DEPTH  = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_mode_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    hwpe_stream_intf_stream.sink    addr_i,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [31:0]             tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    output logic [DATA_WIDTH-1:0]   tcdm_data_o,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
    input  logic                    tcdm_r_valid_i,
    hwpe_stream_intf_stream.source  stream_o,
    hwpe_stream_tcdm_addr_reader_flags_if.master flags_o
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned TAG_W  = STRB_W + 3;
    localparam int unsigned CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(OUT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  expect_q, drop_q;
    logic                  error_q, error_d;
    logic                  credit_ok_s, gnt_s, pop_s;
    logic                  push_data_s, spurious_s;
    logic                  data_empty_s, tag_empty_s, head_valid_s;
    logic [TAG_W-1:0]      tag_in_s, tag_head_s;
    logic [DATA_WIDTH-1:0] data_head_s;
    logic                  unused_s;

    assign unused_s = ^{test_mode_i, addr_i.data[35:33], tag_empty_s};

    assign head_valid_s = ~data_empty_s;
    assign pop_s        = head_valid_s & stream_o.ready;
    // Counting the departing beat as free credit keeps one beat per cycle at OUT_DEPTH=2.
    assign credit_ok_s  = (out_cnt_q < DEPTH_C) | pop_s;
    assign tcdm_req_o   = addr_i.valid & credit_ok_s & enable_i & ~clear_i;
    assign gnt_s        = tcdm_req_o & tcdm_gnt_i;
    assign addr_i.ready = gnt_s;
    assign tcdm_add_o   = {addr_i.data[29:0], 2'b00};
    assign tcdm_wen_o   = 1'b1;
    assign tcdm_be_o    = {STRB_W{1'b1}};
    assign tcdm_data_o  = {DATA_WIDTH{1'b0}};

    assign tag_in_s    = {addr_i.strb, addr_i.data[32:30]};
    assign push_data_s = tcdm_r_valid_i & expect_q & ~drop_q;
    assign spurious_s  = tcdm_r_valid_i & ~expect_q & ~drop_q;

    hwpe_stream_tcdm_addr_reader_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (OUT_DEPTH)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (gnt_s),
        .data_i  (tag_in_s),
        .pop_i   (pop_s),
        .data_o  (tag_head_s),
        .empty_o (tag_empty_s)
    );

    hwpe_stream_tcdm_addr_reader_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (OUT_DEPTH)
    ) i_data_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push_data_s),
        .data_i  (tcdm_r_data_i),
        .pop_i   (pop_s),
        .data_o  (data_head_s),
        .empty_o (data_empty_s)
    );

    assign stream_o.valid = head_valid_s;
    assign stream_o.data  = data_head_s;
    assign stream_o.strb  = head_valid_s ? tag_head_s[TAG_W-1:3] : {STRB_W{1'b0}};

    assign flags_o.busy     = (out_cnt_q != {CNT_W{1'b0}});
    assign flags_o.error    = error_q;
    assign flags_o.misalign = head_valid_s & tag_head_s[2];
    assign flags_o.first    = head_valid_s & tag_head_s[1];
    assign flags_o.last     = head_valid_s & tag_head_s[0];

    // Outstanding-read counter and sticky error next-state.
    always_comb begin
        out_cnt_d = out_cnt_q;
        error_d   = error_q;
        case ({gnt_s, pop_s})
            2'b10:   out_cnt_d = out_cnt_q + CNT_ONE_C;
            2'b01:   out_cnt_d = out_cnt_q - CNT_ONE_C;
            default: out_cnt_d = out_cnt_q;
        endcase
        if (clear_i) begin
            out_cnt_d = {CNT_W{1'b0}};
            error_d   = 1'b0;
        end else if (spurious_s) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Control state; expect_q tracks grants even through a clear so late responses are recognised.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt_q <= {CNT_W{1'b0}};
            expect_q  <= 1'b0;
            drop_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            out_cnt_q <= out_cnt_d;
            expect_q  <= gnt_s;
            drop_q    <= clear_i;
            error_q   <= error_d;
        end
    end
endmodule

// File: tb/tb_hwpe_stream_tcdm_addr_reader.sv
// Directed bench for the TCDM address reader: a per-cycle vector table plus
// hand-written multi-cycle sequences driven through a fixed-latency responder.
module tb_hwpe_stream_tcdm_addr_reader;
    logic        clk = 1'b0;
    logic        rst_n, test_mode, enable, clear;
    logic        tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
    logic [31:0] tcdm_add, tcdm_data, tcdm_r_data;
    logic [3:0]  tcdm_be;

    hwpe_stream_intf_stream #(.DATA_WIDTH(36), .STRB_WIDTH(4)) addr_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(4)) out_if ();
    hwpe_stream_tcdm_addr_reader_flags_if flags_if ();

    hwpe_stream_tcdm_addr_reader #(.OUT_DEPTH(2), .DATA_WIDTH(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .test_mode_i    (test_mode),
        .enable_i       (enable),
        .clear_i        (clear),
        .addr_i         (addr_if),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid),
        .stream_o       (out_if),
        .flags_o        (flags_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, en, clr, av;
        logic [35:0] adata;
        logic [3:0]  astrb;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        ordy;
        logic        req;
        logic [31:0] add;
        logic        ardy, ov;
        logic [31:0] od;
        logic [3:0]  os;
        logic        busy, err, mis, fst, lst;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic auto_resp = 1'b0;

    logic        s_req, s_ardy, s_ov, s_busy, s_err, s_mis, s_fst, s_lst, g_seen, hs_seen;
    logic [31:0] s_add, s_od, g_add;
    logic [3:0]  s_os;

    int idx, nout, ng, nreq, first_g, last_g, first_o, last_o;
    logic [35:0] bdata [3];
    logic [3:0]  bstrb [3];
    logic [2:0]  bflag [3];

    function automatic vec_t mk(input logic r, e, c, av, input logic [35:0] ad, input logic [3:0] as,
                                input logic g, rv, input logic [31:0] rd, input logic rdy,
                                input logic q, input logic [31:0] a, input logic ar, ov,
                                input logic [31:0] od, input logic [3:0] os,
                                input logic b, er, m, f, l);
        vec_t v;
        v.rst_n = r; v.en = e; v.clr = c; v.av = av; v.adata = ad; v.astrb = as;
        v.gnt = g; v.rv = rv; v.rdata = rd; v.ordy = rdy;
        v.req = q; v.add = a; v.ardy = ar; v.ov = ov; v.od = od; v.os = os;
        v.busy = b; v.err = er; v.mis = m; v.fst = f; v.lst = l;
        return v;
    endfunction

    function automatic logic [31:0] resp_of(input logic [31:0] a);
        return 32'hA5A5_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample outputs on the falling edge, advance one cycle, then play the fixed-latency responder.
    task automatic step();
        @(negedge clk);
        s_req = tcdm_req; s_add = tcdm_add; s_ardy = addr_if.ready;
        s_ov = out_if.valid; s_od = out_if.data; s_os = out_if.strb;
        s_busy = flags_if.busy; s_err = flags_if.error;
        s_mis = flags_if.misalign; s_fst = flags_if.first; s_lst = flags_if.last;
        g_seen = tcdm_req & tcdm_gnt; g_add = tcdm_add;
        hs_seen = out_if.valid & out_if.ready;
        @(posedge clk);
        #1;
        cyc++;
        if (auto_resp) begin
            tcdm_r_valid = g_seen;
            tcdm_r_data  = g_seen ? resp_of(g_add) : 32'h0;
        end
    endtask

    initial begin
        rst_n = 1'b0; test_mode = 1'b0; enable = 1'b0; clear = 1'b0;
        tcdm_gnt = 1'b0; tcdm_r_valid = 1'b0; tcdm_r_data = 32'h0;
        addr_if.valid = 1'b0; addr_if.data = 36'h0; addr_if.strb = 4'h0; out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //             rst  en   clr  av   adata            astrb gnt  rv   rdata         ordy | req  add         ardy ov   od            os    busy err  mis  fst  lst
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b0,32'h0,        1'b0, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,36'h0_0000_0100,4'hF,1'b1,1'b0,32'h0,        1'b0, 1'b1,32'h400,  1'b1,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b1,32'hDEADBEEF,1'b0, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,    1'b0,1'b1,32'hDEADBEEF,4'hF,1'b1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b1,32'h12345678,1'b1, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b0,32'h0,        1'b0, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b1,1'b1,36'h0_0000_0008,4'hF,1'b1,1'b0,32'h0,        1'b0, 1'b0,32'h20,   1'b0,1'b0,32'h0,        4'h0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b0,32'h0,        1'b0, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,36'h1_C000_0010,4'h3,1'b1,1'b0,32'h0,        1'b0, 1'b1,32'h40,   1'b1,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b1,1'b0,36'h0,          4'h0,1'b0,1'b1,32'hCAFEF00D,1'b0, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b1,32'hBAD0BAD0,1'b0, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,36'h0_4000_0005,4'h5,1'b1,1'b0,32'h0,        1'b0, 1'b0,32'h14,   1'b0,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,36'h0_4000_0005,4'h5,1'b1,1'b0,32'h0,        1'b0, 1'b1,32'h14,   1'b1,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b1,32'h11112222,1'b0, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,    1'b0,1'b1,32'h11112222,4'h5,1'b1,1'b0,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,36'h0,          4'h0,1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,    1'b0,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,1'b0));

        check("const_wen", tcdm_wen, 1'b1);
        check("const_be", tcdm_be, 4'hF);
        check("const_wdata", tcdm_data, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; enable = vecs[i].en; clear = vecs[i].clr;
            addr_if.valid = vecs[i].av; addr_if.data = vecs[i].adata; addr_if.strb = vecs[i].astrb;
            tcdm_gnt = vecs[i].gnt; tcdm_r_valid = vecs[i].rv; tcdm_r_data = vecs[i].rdata;
            out_if.ready = vecs[i].ordy;
            step();
            check($sformatf("vec%0d_req", i), s_req, vecs[i].req);
            check($sformatf("vec%0d_add", i), s_add, vecs[i].add);
            check($sformatf("vec%0d_addr_ready", i), s_ardy, vecs[i].ardy);
            check($sformatf("vec%0d_out_valid", i), s_ov, vecs[i].ov);
            check($sformatf("vec%0d_busy", i), s_busy, vecs[i].busy);
            check($sformatf("vec%0d_error", i), s_err, vecs[i].err);
            check($sformatf("vec%0d_flags", i), {s_mis, s_fst, s_lst}, {vecs[i].mis, vecs[i].fst, vecs[i].lst});
            if (vecs[i].ov) begin
                check($sformatf("vec%0d_out_data", i), s_od, vecs[i].od);
                check($sformatf("vec%0d_out_strb", i), s_os, vecs[i].os);
            end
        end

        // Back-to-back: eight word addresses, full throughput expected.
        tcdm_r_valid = 1'b0; auto_resp = 1'b1; enable = 1'b1; clear = 1'b0;
        tcdm_gnt = 1'b1; out_if.ready = 1'b1;
        idx = 0; nout = 0; ng = 0; first_g = -1; last_g = -1; first_o = -1; last_o = -1;
        for (int c = 0; c < 40 && nout < 8; c++) begin
            addr_if.valid = (idx < 8);
            addr_if.data  = {6'h0, 30'(idx)};
            addr_if.strb  = 4'hF;
            step();
            if (g_seen) begin
                if (first_g < 0) first_g = cyc;
                last_g = cyc; ng++; idx++;
            end
            if (hs_seen) begin
                if (first_o < 0) first_o = cyc;
                last_o = cyc;
                check($sformatf("b2b_data%0d", nout), s_od, resp_of(32'(nout * 4)));
                nout++;
            end
        end
        check("b2b_beats", nout, 8);
        check("b2b_grants", ng, 8);
        check("b2b_grant_span", last_g - first_g, 7);
        check("b2b_out_span", last_o - first_o, 7);
        check("b2b_latency", first_o - first_g, 2);
        addr_if.valid = 1'b0;
        step();
        step();
        check("b2b_idle_busy", s_busy, 1'b0);

        // Grant stall: request held without grant, address stable, no tag accepted.
        addr_if.valid = 1'b1; addr_if.data = 36'h0_0000_0020; addr_if.strb = 4'hF; tcdm_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d_req", c), s_req, 1'b1);
            check($sformatf("stall%0d_add", c), s_add, 32'h80);
            check($sformatf("stall%0d_ready", c), s_ardy, 1'b0);
            check($sformatf("stall%0d_busy", c), s_busy, 1'b0);
        end
        tcdm_gnt = 1'b1;
        step();
        check("stall_grant_ready", s_ardy, 1'b1);
        addr_if.valid = 1'b0;
        nout = 0; nreq = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_req) nreq++;
            if (hs_seen) begin
                check("stall_data", s_od, resp_of(32'h80));
                nout++;
            end
        end
        check("stall_beats", nout, 1);
        check("stall_extra_req", nreq, 0);

        // Backpressure: two credits fill, then resume with tags intact.
        bdata[0] = 36'h1_8000_0030; bstrb[0] = 4'hC; bflag[0] = 3'b110;
        bdata[1] = 36'h0_4000_0031; bstrb[1] = 4'h3; bflag[1] = 3'b001;
        bdata[2] = 36'h0_0000_0032; bstrb[2] = 4'hF; bflag[2] = 3'b000;
        out_if.ready = 1'b0; idx = 0; ng = 0;
        for (int c = 0; c < 6; c++) begin
            addr_if.valid = (idx < 3);
            addr_if.data  = (idx < 3) ? bdata[idx] : 36'h0;
            addr_if.strb  = (idx < 3) ? bstrb[idx] : 4'h0;
            step();
            if (g_seen) begin ng++; idx++; end
        end
        check("bp_grants", ng, 2);
        check("bp_req_low", s_req, 1'b0);
        check("bp_busy", s_busy, 1'b1);
        out_if.ready = 1'b1; nout = 0;
        for (int c = 0; c < 20 && nout < 3; c++) begin
            addr_if.valid = (idx < 3);
            addr_if.data  = (idx < 3) ? bdata[idx] : 36'h0;
            addr_if.strb  = (idx < 3) ? bstrb[idx] : 4'h0;
            step();
            if (g_seen) begin ng++; idx++; end
            if (hs_seen) begin
                check($sformatf("bp_data%0d", nout), s_od, resp_of(32'h0000_00C0 + 32'(nout * 4)));
                check($sformatf("bp_strb%0d", nout), s_os, bstrb[nout]);
                check($sformatf("bp_flags%0d", nout), {s_mis, s_fst, s_lst}, bflag[nout]);
                nout++;
            end
        end
        check("bp_beats", nout, 3);
        check("bp_total_grants", ng, 3);
        addr_if.valid = 1'b0;
        step();
        step();
        check("bp_idle_busy", s_busy, 1'b0);
        check("bp_idle_error", s_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
